// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the FSM state enum and the stage-control bundle with its constant patterns.
package pipe_ctrl_pkg;

  localparam int DEF_FP_LAT_W = 4;
  localparam int DEF_REG_W    = 5;
  localparam int ZERO_REG     = 0;

  typedef enum logic {
    RUN     = 1'b0,
    FP_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
  } ctrl_t;

  // Normal flow: every register advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                 idex_write: 1'b1, idex_bubble: 1'b0,
                                 exmem_write: 1'b1, exmem_bubble: 1'b0};

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_write: 1'b0, idex_bubble: 1'b1,
                                   exmem_write: 1'b0, exmem_bubble: 1'b1};

  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_write: 1'b0, idex_bubble: 1'b0,
                                    exmem_write: 1'b0, exmem_bubble: 1'b0};

  // FP op keeps EX busy: front end holds, EX/MEM receives bubbles until release.
  localparam ctrl_t CTRL_FP_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_write: 1'b0, idex_bubble: 1'b0,
                                      exmem_write: 1'b1, exmem_bubble: 1'b1};

  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   idex_write: 1'b1, idex_bubble: 1'b1,
                                   exmem_write: 1'b1, exmem_bubble: 1'b0};

  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_write: 1'b1, idex_bubble: 1'b1,
                                      exmem_write: 1'b1, exmem_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Register-compare hit logic between a producing load and a consuming instruction.
// Purely combinational so it can be reused for the FP register file later.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             consumer_valid,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             producer_load,
  input  logic [REG_W-1:0] rw,
  output logic             hit
);

  logic rs_match;
  logic rt_match;
  logic rw_live;

  // Writes to the zero register are discarded, so they never create a dependency.
  assign rw_live  = (rw != REG_W'(ZERO_REG));
  assign rs_match = use_rs && (rs == rw);
  assign rt_match = use_rt && (rt == rw);
  assign hit      = producer_load && consumer_valid && rw_live && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle FP, branch, memory stall.
// Optional PIPE_HAZARD_PERF_EN adds saturating event counters and their output ports.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FP_LAT_W = DEF_FP_LAT_W,
  parameter int REG_W    = DEF_REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_mem_read,
  input  logic [REG_W-1:0]    ex_rW,
  input  logic                ex_fp_multi,
  input  logic [FP_LAT_W-1:0] ex_fp_lat,
  input  logic                branch_taken,
  input  logic                ext_stall,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                idex_write,
  output logic                idex_bubble,
  output logic                exmem_write,
  output logic                exmem_bubble,
  output logic                fp_busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_load_use,
  output logic [31:0]         perf_fp_stall,
  output logic [31:0]         perf_flush
`endif
);

  state_t              state;
  state_t              state_next;
  logic [FP_LAT_W-1:0] cnt;
  logic [FP_LAT_W-1:0] cnt_next;
  logic                lu_hit;
  logic                fp_entry;
  logic                fp_stall;
  logic                do_flush;
  logic                do_load_use;
  ctrl_t               ctrl;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .consumer_valid (id_valid),
    .rs             (id_rs),
    .rt             (id_rt),
    .use_rs         (id_use_rs),
    .use_rt         (id_use_rt),
    .producer_load  (ex_mem_read),
    .rw             (ex_rW),
    .hit            (lu_hit)
  );

  // Latency 0 or 1 completes within the normal EX cycle and needs no stall.
  assign fp_entry    = (state == RUN) && ex_fp_multi && (ex_fp_lat >= FP_LAT_W'(2));
  assign fp_stall    = fp_entry || ((state == FP_WAIT) && (cnt != '0));
  assign do_flush    = (state == RUN) && branch_taken;
  assign do_load_use = (state == RUN) && lu_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!ext_stall) begin
      unique case (state)
        RUN: begin
          if (fp_entry) begin
            state_next = FP_WAIT;
            cnt_next   = ex_fp_lat - FP_LAT_W'(2);
          end
        end
        FP_WAIT: begin
          if (cnt != '0) cnt_next   = cnt - FP_LAT_W'(1);
          else           state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    if (!rst_n)           ctrl = CTRL_RESET;
    else if (ext_stall)   ctrl = CTRL_FREEZE;
    else if (fp_stall)    ctrl = CTRL_FP_STALL;
    else if (do_flush)    ctrl = CTRL_FLUSH;
    else if (do_load_use) ctrl = CTRL_LOAD_USE;
    else                  ctrl = CTRL_RUN;
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_write   = ctrl.idex_write;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_write  = ctrl.exmem_write;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign fp_busy      = rst_n && (state == FP_WAIT);

`ifdef PIPE_HAZARD_PERF_EN
  logic ev_load_use;
  logic ev_fp_stall;
  logic ev_flush;

  // Events mirror the output priority; ext_stall masks all of them, freezing the counters.
  assign ev_fp_stall = !ext_stall && fp_stall;
  assign ev_flush    = !ext_stall && !fp_stall && do_flush;
  assign ev_load_use = !ext_stall && !fp_stall && !do_flush && do_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_use <= '0;
      perf_fp_stall <= '0;
      perf_flush    <= '0;
    end else begin
      if (ev_load_use && (perf_load_use != '1)) perf_load_use <= perf_load_use + 32'd1;
      if (ev_fp_stall && (perf_fp_stall != '1)) perf_fp_stall <= perf_fp_stall + 32'd1;
      if (ev_flush    && (perf_flush    != '1)) perf_flush    <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
